// File: rtl/button_pkg.sv
// Shared definitions for the button input path: FSM state encodings,
// default timing constants and a counter-width helper.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_t;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_DB_CYCLES     = 65536;
  localparam int DEF_LONG_CYCLES   = 12000000;
  localparam int DEF_REPEAT_CYCLES = 3000000;

  // Width of a counter that must hold values 0..n-1. Never below one bit,
  // so that a count of one still gets a real register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser plus debounce counter for one active-low pad input.
// stable_o is the accepted level (1 = pressed). rise_o/fall_o are
// combinational strobes, high in the cycle *before* stable_o changes, so a
// consumer can register its own event outputs on the same edge that
// stable_o flips.
module btn_debounce
  import button_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int DB_W = cnt_width(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("btn_debounce: SYNC_STAGES must be at least 2");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("btn_debounce: DB_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync;
  logic                   stable;
  logic [DB_W-1:0]        cnt;
  logic                   differ;
  logic                   flip;

  // Synchroniser chain; resets to the released (high) pad level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_ff <= '1;
    else     sync_ff <= {sync_ff[SYNC_STAGES-2:0], btn_n};
  end

  assign sync   = ~sync_ff[SYNC_STAGES-1];
  assign differ = sync ^ stable;
  assign flip   = differ && (cnt == DB_LAST);

  // Accept a new level only after it persists; any agreement restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (flip) begin
      stable <= ~stable;
      cnt    <= '0;
    end else if (differ) begin
      cnt    <= cnt + DB_W'(1);
    end else begin
      cnt    <= '0;
    end
  end

  assign stable_o = stable;
  assign rise_o   = flip & ~stable;
  assign fall_o   = flip &  stable;

endmodule

// File: rtl/button_event_decoder.sv
// Button event decoder: raw active-low pad -> debounced level plus
// single-cycle press / release / short / long (/ repeat) pulses.
// Optional auto-repeat is built only when BTN_REPEAT_EN is defined;
// otherwise repeat_o is tied low.
//
// state      | meaning
// ST_IDLE    | button released, waiting for a debounced press
// ST_PRESSED | pressed, counting towards the long-press threshold
// ST_HELD    | long press reported, waiting for release (auto-repeat here)
module button_event_decoder
  import button_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed_o,
  output logic press_o,
  output logic release_o,
  output logic short_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int HOLD_W = cnt_width(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("button_event_decoder: LONG_CYCLES must be at least 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("button_event_decoder: REPEAT_CYCLES must be at least 1");
  end

  logic stable, rise, fall;

  btn_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn_n),
    .stable_o (stable),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  assign pressed_o = stable;

  btn_state_t        state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              press_nxt, release_nxt, short_nxt, long_nxt;

  // Next-state and event decode; the debounce strobes lead stable by one
  // cycle, so the registered pulses line up with the pressed_o edge.
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    short_nxt   = 1'b0;
    long_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        hold_nxt = '0;
        if (rise) begin
          state_nxt = ST_PRESSED;
          press_nxt = 1'b1;
        end
      end
      ST_PRESSED: begin
        // Release takes priority over reaching the long threshold.
        if (fall) begin
          state_nxt   = ST_IDLE;
          release_nxt = 1'b1;
          short_nxt   = 1'b1;
          hold_nxt    = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = ST_HELD;
          long_nxt  = 1'b1;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      ST_HELD: begin
        // hold_cnt stays saturated at the threshold while held.
        if (fall) begin
          state_nxt   = ST_IDLE;
          release_nxt = 1'b1;
          hold_nxt    = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  // State, hold counter and registered event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      short_o   <= 1'b0;
      long_o    <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      press_o   <= press_nxt;
      release_o <= release_nxt;
      short_o   <= short_nxt;
      long_o    <= long_nxt;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int REP_W = cnt_width(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] repeat_cnt, repeat_cnt_nxt;
  logic             repeat_nxt, repeat_q;

  // Repeat tick every REPEAT_CYCLES while held; a release on the tick wins.
  always_comb begin
    repeat_cnt_nxt = '0;
    repeat_nxt     = 1'b0;
    if (state == ST_HELD && !fall) begin
      if (repeat_cnt == REP_LAST) begin
        repeat_nxt     = 1'b1;
        repeat_cnt_nxt = '0;
      end else begin
        repeat_cnt_nxt = repeat_cnt + REP_W'(1);
      end
    end
  end

  // Repeat counter and registered repeat pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      repeat_cnt <= '0;
      repeat_q   <= 1'b0;
    end else begin
      repeat_cnt <= repeat_cnt_nxt;
      repeat_q   <= repeat_nxt;
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with short timing parameters.
// Outputs are checked as one vector {pressed, press, release, short, long, repeat}.
module tb_button_event_decoder;

  logic clk, rst, btn_n;
  logic pressed_o, press_o, release_o, short_o, long_o, repeat_o;
  logic [5:0] outs;
  int total = 0;
  int bad   = 0;

  button_event_decoder #(
    .SYNC_STAGES   (2),
    .DB_CYCLES     (4),
    .LONG_CYCLES   (16),
    .REPEAT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_n),
    .pressed_o (pressed_o),
    .press_o   (press_o),
    .release_o (release_o),
    .short_o   (short_o),
    .long_o    (long_o),
    .repeat_o  (repeat_o)
  );

  assign outs = {pressed_o, press_o, release_o, short_o, long_o, repeat_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    total++;
    assert (outs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
      end
  endtask

  // Expected repeat pulse m cycles after press_o (long_o lands at m=16).
  function automatic logic rep_exp(input int m);
`ifdef BTN_REPEAT_EN
    return (m > 16) && (((m - 16) % 8) == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Drive a press: first low sample at the next edge, press_o five edges later.
  task automatic press_seq(input string tag);
    btn_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk({tag, "_wait"}, 6'b000000);
    end
    step();
    chk({tag, "_press"}, 6'b110000);
  endtask

  initial begin
    rst   = 1'b1;
    btn_n = 1'b1;
    step();
    step();
    chk("reset", 6'b000000);
    rst = 1'b0;
    step();
    step();
    chk("idle", 6'b000000);

    // Clean short press
    press_seq("t1");
    for (int m = 1; m <= 5; m++) begin
      step();
      chk("t1_hold", 6'b100000);
    end
    btn_n = 1'b1;
    for (int m = 6; m <= 10; m++) begin
      step();
      chk("t1_rel_wait", 6'b100000);
    end
    step();
    chk("t1_release", 6'b001100);
    step();
    chk("t1_after", 6'b000000);

    // Bounce of 3 low samples is rejected
    btn_n = 1'b0;
    repeat (3) step();
    btn_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t2_bounce", 6'b000000);
    end
    // 4 low samples is just enough
    btn_n = 1'b0;
    repeat (4) step();
    btn_n = 1'b1;
    step();
    chk("t2_four_wait", 6'b000000);
    step();
    chk("t2_four_press", 6'b110000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_four_hold", 6'b100000);
    end
    step();
    chk("t2_four_release", 6'b001100);
    step();
    step();
    chk("t2_after", 6'b000000);

    // Long hold: long_o 16 cycles after press_o, repeat (if built) every 8
    press_seq("t3");
    for (int m = 1; m <= 45; m++) begin
      step();
      chk("t3_hold", {1'b1, 3'b000, (m == 16), rep_exp(m)});
      if (m == 40) btn_n = 1'b1;
    end
    step();
    chk("t3_release", 6'b001000);
    step();
    chk("t3_after", 6'b000000);

    // Release lands on the long threshold cycle: short wins
    press_seq("t4");
    for (int m = 1; m <= 15; m++) begin
      step();
      chk("t4_hold", 6'b100000);
      if (m == 10) btn_n = 1'b1;
    end
    step();
    chk("t4_coincide", 6'b001100);
    step();
    chk("t4_after", 6'b000000);

    // Reset asserted mid-HELD with the button still down
    press_seq("t5");
    for (int m = 1; m <= 20; m++) begin
      step();
      chk("t5_hold", {1'b1, 3'b000, (m == 16), rep_exp(m)});
    end
    #2 rst = 1'b1;
    #1 chk("t5_async_clear", 6'b000000);
    step();
    chk("t5_in_reset", 6'b000000);
    step();
    chk("t5_in_reset", 6'b000000);
    rst = 1'b0;
    press_seq("t5_re");
    btn_n = 1'b1;
    for (int m = 1; m <= 5; m++) begin
      step();
      chk("t5_re_hold", 6'b100000);
    end
    step();
    chk("t5_release", 6'b001100);
    step();
    chk("t5_after", 6'b000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
